multicycle_ctrl: RTL and testbench

//   Multi-cycle control FSM sequencing the MIPS datapath: fetch -> decode -> execute -> memory -> writeback.

---
 rtl/multicycle_ctrl.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// multicycle_ctrl
//   Multi-cycle control FSM for a MIPS-subset datapath. Each instruction moves
//   through FETCH -> DECODE -> EXEC -> MEM -> WB, skipping the phases it does
//   not need. The FSM drives every datapath strobe and select, plus the
//   imem/dmem request handshakes. It counts retired instructions and traps on
//   an illegal instruction or on a memory acknowledge that never arrives.
//
// Parameters
//   CNT_W       width of the retired-instruction counter (wraps to 0)
//   TIMEOUT     max cycles spent waiting for an ack before trapping; 0 = never
//
// Ports
//   clk         clock, rising edge
//   rst_n       synchronous active-low reset
//   opcode      IR[31:26]
//   funct       IR[5:0]
//   zero        ALU zero flag, used by beq
//   imem_ack    instruction word valid this cycle
//   dmem_ack    data access complete this cycle
//   imem_req    instruction fetch request
//   dmem_req    data memory request
//   dmem_we     data memory write (sw)
//   ir_we       latch the instruction register
//   pc_we       update the PC
//   pc_src      PC source: 0 pc+4, 1 branch target, 2 jump target, 3 rs
//   rf_we       register file write
//   reg_dst     destination register: 0 rt, 1 rd
//   alu_src     ALU operand B: 0 rt, 1 sign-extended immediate
//   alu_op      0 add, 1 sub, 2 and, 3 or, 4 slt, 5 sll
//   mem_to_reg  write-back source: 0 ALU result, 1 load data
//   state       current FSM state
//   trap_cause  0 none, 1 illegal, 2 imem timeout, 3 dmem timeout
//   instret     retired-instruction count
// ============================================================================
module multicycle_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             rf_we,
    output logic             reg_dst,
    output logic             alu_src,
    output logic [2:0]       alu_op,
    output logic             mem_to_reg,
    output logic [2:0]       state,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // R-type function codes
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2a;

    // ALU operations
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;
    localparam logic [2:0] ALU_SLL = 3'd5;

    // Trap causes
    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_IMEM_TO = 2'd2;
    localparam logic [1:0] CAUSE_DMEM_TO = 2'd3;

    // The wait counter only has to reach TIMEOUT-1.
    localparam int              WAIT_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam bit              TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e             state_q,      state_d;
    logic [CNT_W-1:0]   instret_q,    instret_d;
    logic [1:0]         trap_cause_q, trap_cause_d;
    logic [WAIT_W-1:0]  wait_cnt_q,   wait_cnt_d;

    // ------------------------------------------------------------------
    // Instruction decode (IR is stable from DECODE onwards)
    // ------------------------------------------------------------------
    logic is_rtype, is_j, is_jr, is_beq, is_addi, is_lw, is_sw;
    logic rtype_ok, legal;

    assign is_rtype = (opcode == OP_RTYPE);
    assign is_j     = (opcode == OP_J);
    assign is_jr    = is_rtype && (funct == FN_JR);
    assign is_beq   = (opcode == OP_BEQ);
    assign is_addi  = (opcode == OP_ADDI);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);

    assign rtype_ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                      (funct == FN_OR)  || (funct == FN_SLT) || (funct == FN_SLL) ||
                      (funct == FN_JR);
    assign legal    = is_rtype ? rtype_ok
                               : (is_j || is_beq || is_addi || is_lw || is_sw);

    function automatic logic [2:0] funct_to_alu(input logic [5:0] fn);
        case (fn)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            FN_SLL:  return ALU_SLL;
            default: return ALU_ADD;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        instret_d    = instret_q;
        trap_cause_d = trap_cause_q;
        wait_cnt_d   = '0;          // clears on any ack or state change
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = 2'd0;
        rf_we        = 1'b0;
        reg_dst      = 1'b0;
        alu_src      = 1'b0;
        alu_op       = ALU_ADD;
        mem_to_reg   = 1'b0;

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (TIMEOUT_EN && (wait_cnt_q == WAIT_LAST)) begin
                    state_d      = S_TRAP;
                    trap_cause_d = CAUSE_IMEM_TO;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            S_DECODE: begin
                if (!legal) begin
                    state_d      = S_TRAP;
                    trap_cause_d = CAUSE_ILLEGAL;
                end else if (is_j) begin
                    pc_we     = 1'b1;
                    pc_src    = 2'd2;
                    instret_d = instret_q + 1'b1;
                    state_d   = S_FETCH;
                end else if (is_jr) begin
                    pc_we     = 1'b1;
                    pc_src    = 2'd3;
                    instret_d = instret_q + 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                alu_src = is_lw || is_sw || is_addi;
                if (is_rtype) begin
                    alu_op = funct_to_alu(funct);
                end else if (is_beq) begin
                    alu_op = ALU_SUB;
                end
                if (is_beq) begin
                    // The branch retires here whether or not it is taken.
                    pc_we     = zero;
                    pc_src    = 2'd1;
                    instret_d = instret_q + 1'b1;
                    state_d   = S_FETCH;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end

            S_MEM: begin
                // Address operands stay on the ALU for the whole access.
                dmem_req = 1'b1;
                dmem_we  = is_sw;
                alu_src  = 1'b1;
                alu_op   = ALU_ADD;
                if (dmem_ack) begin
                    if (is_sw) begin
                        instret_d = instret_q + 1'b1;
                        state_d   = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (TIMEOUT_EN && (wait_cnt_q == WAIT_LAST)) begin
                    state_d      = S_TRAP;
                    trap_cause_d = CAUSE_DMEM_TO;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            S_WB: begin
                rf_we      = 1'b1;
                reg_dst    = is_rtype;
                mem_to_reg = is_lw;
                instret_d  = instret_q + 1'b1;
                state_d    = S_FETCH;
            end

            S_TRAP: begin
                // Parked until reset; all strobes stay at their defaults.
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset drops any outstanding request immediately, not at the edge.
        if (!rst_n) begin
            imem_req   = 1'b0;
            dmem_req   = 1'b0;
            dmem_we    = 1'b0;
            ir_we      = 1'b0;
            pc_we      = 1'b0;
            pc_src     = 2'd0;
            rf_we      = 1'b0;
            reg_dst    = 1'b0;
            alu_src    = 1'b0;
            alu_op     = ALU_ADD;
            mem_to_reg = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rst_n) begin
            state_q      <= S_FETCH;
            instret_q    <= '0;
            trap_cause_q <= CAUSE_NONE;
            wait_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            instret_q    <= instret_d;
            trap_cause_q <= trap_cause_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    assign state      = state_q;
    assign trap_cause = trap_cause_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// tb_multicycle_ctrl
//   Directed test of multicycle_ctrl with CNT_W=4 (so the retired counter
//   wraps quickly) and TIMEOUT=16. Inputs change 1 ns after a rising edge;
//   outputs are compared 1 ns later, well clear of the next edge.
// ============================================================================
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       imem_ack;
    logic       dmem_ack;
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       rf_we;
    logic       reg_dst;
    logic       alu_src;
    logic [2:0] alu_op;
    logic       mem_to_reg;
    logic [2:0] state;
    logic [1:0] trap_cause;
    logic [3:0] instret;

    int n_vec = 0;
    int n_err = 0;

    multicycle_ctrl #(
        .CNT_W   (4),
        .TIMEOUT (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .imem_ack   (imem_ack),
        .dmem_ack   (dmem_ack),
        .imem_req   (imem_req),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .rf_we      (rf_we),
        .reg_dst    (reg_dst),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .mem_to_reg (mem_to_reg),
        .state      (state),
        .trap_cause (trap_cause),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_vec++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction in FETCH with an immediate ack; returns settled
    // in DECODE with imem_ack low again.
    task automatic fetch(input logic [5:0] op, input logic [5:0] fn);
        opcode   = op;
        funct    = fn;
        imem_ack = 1'b1;
        #1;
        check("fetch_state", 32'(state), 0);
        check("fetch_ir_we", 32'(ir_we), 1);
        check("fetch_pc_we", 32'(pc_we), 1);
        tick();
        imem_ack = 1'b0;
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        opcode   = 6'h00;
        funct    = 6'h20;
        zero     = 1'b0;
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        #2;
        // Strobes are gated while reset is low, even with acks present.
        check("rst_imem_req", 32'(imem_req), 0);
        check("rst_ir_we",    32'(ir_we),    0);
        tick();
        tick();
        check("rst_state", 32'(state),      0);
        check("rst_instr", 32'(instret),    0);
        check("rst_cause", 32'(trap_cause), 0);
        rst_n    = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        #1;
        check("fetch_req", 32'(imem_req), 1);

        // ---- R-type add: FETCH, DECODE, EXEC, WB ----
        fetch(6'h00, 6'h20);
        imem_ack = 1'b1;     // acks outside their request state are ignored
        dmem_ack = 1'b1;
        #1;
        check("add_dec_state", 32'(state),    1);
        check("add_dec_ireq",  32'(imem_req), 0);
        check("add_dec_dreq",  32'(dmem_req), 0);
        check("add_dec_pcwe",  32'(pc_we),    0);
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        tick();
        check("add_ex_state",  32'(state),   2);
        check("add_ex_aluop",  32'(alu_op),  0);
        check("add_ex_alusrc", 32'(alu_src), 0);
        check("add_ex_rfwe",   32'(rf_we),   0);
        tick();
        check("add_wb_state",  32'(state),      4);
        check("add_wb_rfwe",   32'(rf_we),      1);
        check("add_wb_regdst", 32'(reg_dst),    1);
        check("add_wb_m2r",    32'(mem_to_reg), 0);
        tick();
        check("add_ret_state", 32'(state),   0);
        check("add_instret",   32'(instret), 1);

        // ---- R-type slt and sub: alu_op follows funct ----
        fetch(6'h00, 6'h2a);
        tick();
        check("slt_aluop", 32'(alu_op), 4);
        tick();
        tick();
        check("slt_instret", 32'(instret), 2);
        fetch(6'h00, 6'h22);
        tick();
        check("sub_aluop", 32'(alu_op), 1);
        tick();
        tick();
        check("sub_instret", 32'(instret), 3);

        // ---- lw with dmem_ack delayed 3 cycles ----
        fetch(6'h23, 6'h00);
        check("lw_dec_state", 32'(state), 1);
        tick();
        check("lw_ex_state",  32'(state),   2);
        check("lw_ex_alusrc", 32'(alu_src), 1);
        check("lw_ex_aluop",  32'(alu_op),  0);
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                dmem_ack = 1'b1;
                #1;
            end
            check("lw_mem_state", 32'(state),    3);
            check("lw_mem_dreq",  32'(dmem_req), 1);
            check("lw_mem_dwe",   32'(dmem_we),  0);
            tick();
        end
        dmem_ack = 1'b0;
        #1;
        check("lw_wb_state",  32'(state),      4);
        check("lw_wb_rfwe",   32'(rf_we),      1);
        check("lw_wb_m2r",    32'(mem_to_reg), 1);
        check("lw_wb_regdst", 32'(reg_dst),    0);
        tick();
        check("lw_instret", 32'(instret), 4);

        // ---- sw with immediate ack ----
        fetch(6'h2b, 6'h00);
        tick();
        tick();
        dmem_ack = 1'b1;
        #1;
        check("sw_mem_dreq", 32'(dmem_req), 1);
        check("sw_mem_dwe",  32'(dmem_we),  1);
        tick();
        dmem_ack = 1'b0;
        #1;
        check("sw_ret_state", 32'(state),   0);
        check("sw_instret",   32'(instret), 5);

        // ---- addi ----
        fetch(6'h08, 6'h00);
        tick();
        check("addi_ex_alusrc", 32'(alu_src), 1);
        tick();
        check("addi_wb_rfwe",   32'(rf_we),      1);
        check("addi_wb_regdst", 32'(reg_dst),    0);
        check("addi_wb_m2r",    32'(mem_to_reg), 0);
        tick();
        check("addi_instret", 32'(instret), 6);

        // ---- beq taken, then not taken ----
        fetch(6'h04, 6'h00);
        tick();
        zero = 1'b1;
        #1;
        check("beq1_state",  32'(state),  2);
        check("beq1_pcwe",   32'(pc_we),  1);
        check("beq1_pcsrc",  32'(pc_src), 1);
        check("beq1_aluop",  32'(alu_op), 1);
        tick();
        check("beq1_ret_state", 32'(state),   0);
        check("beq1_instret",   32'(instret), 7);
        fetch(6'h04, 6'h00);
        tick();
        zero = 1'b0;
        #1;
        check("beq0_state", 32'(state), 2);
        check("beq0_pcwe",  32'(pc_we), 0);
        tick();
        check("beq0_instret", 32'(instret), 8);

        // ---- j and jr retire from DECODE ----
        fetch(6'h02, 6'h00);
        check("j_pcwe",  32'(pc_we),  1);
        check("j_pcsrc", 32'(pc_src), 2);
        tick();
        check("j_ret_state", 32'(state),   0);
        check("j_instret",   32'(instret), 9);
        fetch(6'h00, 6'h08);
        check("jr_pcwe",  32'(pc_we),  1);
        check("jr_pcsrc", 32'(pc_src), 3);
        tick();
        check("jr_instret", 32'(instret), 10);

        // ---- imem ack arriving on the 16th waiting cycle: no trap ----
        opcode = 6'h02;
        funct  = 6'h00;
        for (int i = 0; i < 15; i++) begin
            check("late_ack_wait", 32'(state), 0);
            tick();
        end
        imem_ack = 1'b1;
        #1;
        tick();
        imem_ack = 1'b0;
        #1;
        check("late_ack_state", 32'(state),      1);
        check("late_ack_cause", 32'(trap_cause), 0);
        tick();
        check("late_ack_instret", 32'(instret), 11);

        // ---- imem never acks: trap after 16 FETCH cycles ----
        for (int i = 0; i < 16; i++) begin
            check("imem_to_wait", 32'(state), 0);
            tick();
        end
        check("imem_to_state", 32'(state),      5);
        check("imem_to_cause", 32'(trap_cause), 2);
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        #1;
        check("trap_ireq", 32'(imem_req), 0);
        check("trap_dreq", 32'(dmem_req), 0);
        check("trap_irwe", 32'(ir_we),    0);
        tick();
        check("trap_hold_state", 32'(state),      5);
        check("trap_hold_cause", 32'(trap_cause), 2);
        check("trap_hold_instr", 32'(instret),    11);

        // ---- reset, then an illegal opcode ----
        rst_n    = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        tick();
        check("rst2_state", 32'(state),      0);
        check("rst2_cause", 32'(trap_cause), 0);
        check("rst2_instr", 32'(instret),    0);
        rst_n = 1'b1;
        fetch(6'h3f, 6'h00);
        check("ill_dec_state", 32'(state), 1);
        check("ill_dec_pcwe",  32'(pc_we), 0);
        tick();
        check("ill_state", 32'(state),      5);
        check("ill_cause", 32'(trap_cause), 1);
        check("ill_rfwe",  32'(rf_we),      0);
        rst_n = 1'b0;
        tick();
        check("rst3_state", 32'(state),      0);
        check("rst3_cause", 32'(trap_cause), 0);
        rst_n = 1'b1;

        // ---- unsupported R-type funct is also illegal ----
        fetch(6'h00, 6'h21);
        tick();
        check("ill_fn_state", 32'(state),      5);
        check("ill_fn_cause", 32'(trap_cause), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // ---- dmem never acks: trap after 16 MEM cycles ----
        fetch(6'h23, 6'h00);
        tick();
        tick();
        for (int i = 0; i < 16; i++) begin
            check("dmem_to_wait", 32'(state), 3);
            tick();
        end
        check("dmem_to_state", 32'(state),      5);
        check("dmem_to_cause", 32'(trap_cause), 3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // ---- 17 jumps: 4-bit instret wraps 15 -> 0 -> 1 ----
        for (int k = 1; k <= 17; k++) begin
            fetch(6'h02, 6'h00);
            tick();
            check("wrap_instret", 32'(instret), 32'(k % 16));
        end

        // ---- reset asserted mid-access drops the data request ----
        fetch(6'h23, 6'h00);
        tick();
        tick();
        check("mem_rst_pre_dreq", 32'(dmem_req), 1);
        rst_n = 1'b0;
        #1;
        check("mem_rst_dreq_now", 32'(dmem_req), 0);
        tick();
        check("mem_rst_state", 32'(state),    0);
        check("mem_rst_dreq",  32'(dmem_req), 0);
        check("mem_rst_instr", 32'(instret),  0);
        rst_n = 1'b1;
        #1;
        check("mem_rst_ireq", 32'(imem_req), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Safety net in case the sequence above ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d vectors, %0d miscompares",
                 n_vec, n_err);
        $fatal(1);
    end

endmodule
